cheat_code_loader: RTL
======================

// Module: cheat_code_loader
// PURPOSE
//  Upstream feeder for the cheat-code match stage. Takes the cheat file as a byte stream from
//  the download path and assembles each 16-byte record into the 129-bit code bus
//  {strobe, flags[127:96], addr[95:64], compare[63:32], replace[31:0]}. Records are big-endian
//  and are shifted in MSB first. The block raises one strobe per complete record and clears the
//  match stage at the start of each download.
// PARAMETERS
//  MAX_CODES      32  records forwarded per download; later records are dropped
//  STROBE_CYCLES  2   cycles code[128] is held high, then held low, per record (>=1)
// PORTS
//  clk          in   1    system clock; the only clock
//  reset_n      in   1    synchronous, active-low reset
//  dl_start     in   1    1-cycle pulse: a new cheat download begins
//  dl_wr        in   1    byte valid; the source holds dl_data until accepted
//  dl_data      in   8    stream byte
//  dl_done      in   1    1-cycle pulse: the download has ended
//  dl_ready     out  1    byte accepted when dl_wr && dl_ready
//  codes_clear  out  1    active-high clear to the match stage
//  code         out  129  code bus to the match stage; bit 128 is the strobe
//  code_count   out  $clog2(MAX_CODES+1)  records strobed since the last clear
//  overflow     out  1    sticky: a complete record arrived with code_count==MAX_CODES
//  err_partial  out  1    sticky: dl_done arrived with 1..15 bytes of a record pending
//  busy         out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset (reset_n==0 at posedge): state IDLE. All outputs go to 0, including dl_ready,
//    codes_clear and code. byte_cnt and the shift register also go to 0.
//  FSM states: IDLE, CLEAR, COLLECT, STR_HI, STR_LO, FINISH.
//   IDLE: on dl_start -> CLEAR. All other inputs are ignored.
//   CLEAR (1 cycle):
//    - codes_clear=1; code_count, overflow, err_partial and byte_cnt are zeroed.
//    - code[127:0]=0; then -> COLLECT.
//   COLLECT: dl_ready=1. On each accepted byte:
//    - sh <= {sh[119:0], dl_data}; byte_cnt increments mod 16.
//    - If the accepted byte is the 16th (byte_cnt==15) and code_count<MAX_CODES:
//      code[127:0] <= {sh[119:0], dl_data}, code[128] <= 1, code_count++, -> STR_HI.
//      dl_ready drops in the next cycle.
//    - If it is the 16th and code_count==MAX_CODES: overflow <= 1, the record is
//      discarded, and the block stays in COLLECT.
//   STR_HI: code[128]=1 for STROBE_CYCLES cycles, then code[128] <= 0 -> STR_LO.
//   STR_LO: code[128]=0 for STROBE_CYCLES cycles, then -> COLLECT, or -> FINISH if
//    done_pend is set.
//   FINISH (1 cycle): done_pend cleared -> IDLE.
//  code[127:0] changes only on the cycle code[128] rises, so it is stable for the whole strobe.
//  Latency: 16th byte accepted at cycle N -> code[128]=1 at N+1 -> code[128]=0 at
//    N+1+STROBE_CYCLES -> dl_ready=1 again at N+1+2*STROBE_CYCLES.
//  dl_done:
//   - In COLLECT with byte_cnt!=0 and no 16th byte that cycle: err_partial <= 1, the
//     partial record is discarded, -> FINISH.
//   - In COLLECT with byte_cnt==0: -> FINISH.
//   - In STR_HI/STR_LO: done_pend <= 1; the strobe completes first.
//   - Same cycle as the 16th byte: that byte is accepted, the strobe runs, then -> FINISH.
//  dl_start in any non-IDLE state: abort -> CLEAR.
//   - code[128] is forced to 0 the same cycle and any pending record is dropped.
//   - If dl_start and dl_wr coincide, dl_start wins and the byte is not accepted
//     (dl_ready=0 in that cycle is fine).
//  Width rules:
//   - byte_cnt is 4 bits and wraps 15->0 only on accept.
//   - code_count saturates at MAX_CODES.
//   - Field width trimming is done by the consumer; all 32 bits of each field are passed.
//  dl_wr while dl_ready==0: no effect; the byte stays pending at the source.
// TESTING
//  1 reset_n=0 for 2 cycles mid-strobe -> code==0, code_count==0, dl_ready==0, state IDLE.
//  2 dl_start, then 16 bytes 00 00 00 01 | 00 00 C0 10 | 00 00 00 00 | 00 00 00 EA ->
//    codes_clear high for 1 cycle; code=={1,0x00000001,0x0000C010,0x0,0x000000EA};
//    strobe high for exactly 2 cycles; code_count==1.
//  3 34 back-to-back records with MAX_CODES=32 -> exactly 32 strobes, code_count==32,
//    overflow==1, no strobe for records 33 and 34.
//  4 dl_done after 7 bytes of a record -> no strobe, err_partial==1, busy low 2 cycles later.
//  5 dl_done on the 16th-byte cycle -> that strobe still occurs (2 high, 2 low), then IDLE.
//  6 dl_start during STR_HI -> code[128]=0 next cycle, codes_clear pulse, code_count==0.

Source files
------------

// File: rtl/cheat_code_loader_if.sv
// rtl/cheat_code_loader_if.sv - download byte stream in, code bus and status out
interface cheat_code_loader_if #(
   parameter int MAX_CODES = 32
);
   logic                               dl_start;
   logic                               dl_wr;
   logic [7:0]                         dl_data;
   logic                               dl_done;
   logic                               dl_ready;
   logic                               codes_clear;
   logic [128:0]                       code;
   logic [$clog2(MAX_CODES+1)-1:0]     code_count;
   logic                               overflow;
   logic                               err_partial;
   logic                               busy;

   // master is the download source; slave is the loader
   modport master (
      output dl_start, dl_wr, dl_data, dl_done,
      input  dl_ready, codes_clear, code, code_count, overflow, err_partial, busy
   );

   modport slave (
      input  dl_start, dl_wr, dl_data, dl_done,
      output dl_ready, codes_clear, code, code_count, overflow, err_partial, busy
   );
endinterface

// File: rtl/cheat_code_loader.sv
// rtl/cheat_code_loader.sv - assembles 16-byte big-endian cheat records onto a strobed 129-bit code bus
module cheat_code_loader #(
   parameter int MAX_CODES     = 32,
   parameter int STROBE_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   cheat_code_loader_if.slave    bus
);
   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_COLLECT = 3'd2;
   localparam logic [2:0] S_STR_HI  = 3'd3;
   localparam logic [2:0] S_STR_LO  = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   localparam int CW = $clog2(MAX_CODES + 1);
   localparam int SW = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;
   localparam logic [SW-1:0] STB_LAST = SW'(STROBE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_CODES);

   logic [2:0]    state;
   logic [119:0]  sh;
   logic [3:0]    byte_cnt;
   logic [SW-1:0] stb_cnt;
   logic          done_pend;
   logic [128:0]  code_r;
   logic [CW-1:0] code_count_r;
   logic          overflow_r;
   logic          err_partial_r;
   logic          accept;
   logic [127:0]  rec;

   // dl_start takes priority over a coinciding byte, so ready is withheld that cycle
   assign bus.dl_ready    = (state == S_COLLECT) && !bus.dl_start;
   assign accept          = bus.dl_ready && bus.dl_wr;
   assign rec             = {sh, bus.dl_data};
   assign bus.codes_clear = (state == S_CLEAR);
   assign bus.busy        = (state != S_IDLE);
   assign bus.code        = code_r;
   assign bus.code_count  = code_count_r;
   assign bus.overflow    = overflow_r;
   assign bus.err_partial = err_partial_r;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state         <= S_IDLE;
         sh            <= '0;
         byte_cnt      <= '0;
         stb_cnt       <= '0;
         done_pend     <= 1'b0;
         code_r        <= '0;
         code_count_r  <= '0;
         overflow_r    <= 1'b0;
         err_partial_r <= 1'b0;
      end else if (bus.dl_start) begin
         state     <= S_CLEAR;
         code_r    <= '0;
         byte_cnt  <= '0;
         stb_cnt   <= '0;
         done_pend <= 1'b0;
      end else begin
         case (state)
            S_CLEAR: begin
               code_r        <= '0;
               code_count_r  <= '0;
               overflow_r    <= 1'b0;
               err_partial_r <= 1'b0;
               byte_cnt      <= '0;
               state         <= S_COLLECT;
            end
            S_COLLECT: begin
               if (accept) begin
                  sh       <= rec[119:0];
                  byte_cnt <= byte_cnt + 4'd1;
               end
               if (accept && byte_cnt == 4'd15) begin
                  if (code_count_r != CNT_MAX) begin
                     code_r       <= {1'b1, rec};
                     code_count_r <= code_count_r + 1'b1;
                     stb_cnt      <= '0;
                     done_pend    <= bus.dl_done;
                     state        <= S_STR_HI;
                  end else begin
                     overflow_r <= 1'b1;
                     if (bus.dl_done)
                        state <= S_FINISH;
                  end
               end else if (bus.dl_done) begin
                  // the trailing partial record is dropped
                  if (byte_cnt != 4'd0)
                     err_partial_r <= 1'b1;
                  byte_cnt <= '0;
                  state    <= S_FINISH;
               end
            end
            S_STR_HI: begin
               if (bus.dl_done)
                  done_pend <= 1'b1;
               if (stb_cnt == STB_LAST) begin
                  code_r[128] <= 1'b0;
                  stb_cnt     <= '0;
                  state       <= S_STR_LO;
               end else begin
                  stb_cnt <= stb_cnt + 1'b1;
               end
            end
            S_STR_LO: begin
               if (bus.dl_done)
                  done_pend <= 1'b1;
               if (stb_cnt == STB_LAST) begin
                  stb_cnt <= '0;
                  state   <= (done_pend || bus.dl_done) ? S_FINISH : S_COLLECT;
               end else begin
                  stb_cnt <= stb_cnt + 1'b1;
               end
            end
            S_FINISH: begin
               done_pend <= 1'b0;
               state     <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
